multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Iterative signed multiply/divide unit with its own sequencing FSM and stall handshake.
- Sits beside the ALU in the execute stage of the 5-bit-opcode processor.
- Started by one-cycle pulses that the execute stage raises when it decodes an R-type mult or div.
- Holds the pipeline through `busy` until `result_rdy` pulses.

Parameters:
- WIDTH, 32, operand and result width in bits. Legal values are 8 or greater.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ctrl_mult  in  1  start-multiply pulse.
- ctrl_div  in  1  start-divide pulse.
- operand_a  in  WIDTH  multiplicand or dividend, signed two's complement. Sampled only on a start cycle.
- operand_b  in  WIDTH  multiplier or divisor, signed. Sampled only on a start cycle.
- result  out  WIDTH  product low bits or quotient. Held until the next start.
- exception  out  1  overflow or divide-by-zero. Valid with result_rdy and held with result.
- result_rdy  out  1  one-cycle pulse when result and exception are valid.
- busy  out  1  high from the cycle after a start until the result_rdy cycle, inclusive. Drives the pipeline stall.

Behaviour:
- Reset: reset_n low asynchronously forces the following, regardless of the operation in progress.
  - State goes to IDLE and the counter to 0.
  - result=0, exception=0, result_rdy=0, busy=0.
  - Internal operand, accumulator and remainder registers go to 0.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating.
  - DONE: result_rdy=1 for exactly one cycle, then back to IDLE.
- Start: a start is any cycle with ctrl_mult or ctrl_div high, in any state.
  - On a start, latch the operand magnitudes, the result sign (sign(a) XOR sign(b)), the op type and any special-case flags.
  - Clear the counter and enter RUN, or enter DONE for the special cases below.
  - If ctrl_mult and ctrl_div are high together, multiply wins.
  - A start during RUN or DONE aborts the current op and restarts with the new operands. The DONE pulse of the aborted op is suppressed.
- Multiply:
  - Radix-2 shift-add on magnitudes, one bit per cycle, WIDTH cycles in RUN.
  - The 2*WIDTH magnitude product is negated if the result sign is 1.
  - result = low WIDTH bits of the product.
  - exception=1 if the upper WIDTH+1 bits of the signed product are not all equal (the product does not fit in signed WIDTH).
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles in RUN.
  - Quotient truncates toward zero and is negated if the result sign is 1. The remainder is discarded.
  - Divide by zero (operand_b==0, detected at start): go straight to DONE, result=0, exception=1.
  - MIN/-1 (a=1<<(WIDTH-1), b=all ones): run normally, result=0x8000_0000 (for WIDTH=32), exception=1.
- Latency:
  - For a start in cycle T, result_rdy is high in cycle T+WIDTH+1 (T+33 at default), and busy is high for T+1 through T+WIDTH+1.
  - Special cases that go straight to DONE give result_rdy at T+1.
- Update timing: result and exception update only in the cycle entering DONE, so they are registered and stable during the result_rdy pulse.
- Counter: counts 0 to WIDTH-1 in RUN; the transition to DONE happens when the counter equals WIDTH-1. It never wraps.
- Pulses while IDLE are starts; nothing else changes state.

Optional Feature:
- MULTDIV_EARLY_OUT_EN
- Defined: a multiply with operand_a==0 or operand_b==0, or a divide with operand_a==0 and operand_b!=0, goes straight to DONE. result=0, exception=0, result_rdy at T+1.
- Undefined: these cases take the full WIDTH+1 latency with identical result and exception.
- Divide-by-zero takes the one-cycle path in both builds.

Test Plan:
- Multiply: reset, then ctrl_mult with a=7, b=-6 -> result_rdy only at T+33, result=0xFFFF_FFD6 (-42), exception=0, busy high for T+1 through T+33.
- Multiply overflow: ctrl_mult with a=0x0001_0000, b=0x0001_0000 -> result=0, exception=1. Then a=-0x8000, b=0x10000 -> result=0x8000_0000, exception=0.
- Divide: ctrl_div with a=-7, b=2 -> result=-3 (0xFFFF_FFFD), exception=0 at T+33. Then a=5, b=0 -> result_rdy at T+1, result=0, exception=1. Then a=0x8000_0000, b=-1 -> result=0x8000_0000, exception=1.
- Abort: ctrl_mult with a=3, b=4, then ctrl_div with a=100, b=7 at T+10 -> no result_rdy before T+10+33, then exactly one pulse with result=14.
- Simultaneous start and reset: ctrl_mult and ctrl_div high together with a=6, b=3 -> result=18.
  - Drop reset_n at T+20 of a divide -> all outputs 0 immediately, with no result_rdy later.
  - After release, a new op completes normally.
- Early out (MULTDIV_EARLY_OUT_EN both ways): multiply with a=0, b=123.
  - Defined: result_rdy at T+1, result=0.
  - Undefined: result_rdy at T+33, result=0.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide unit (shift-add / restoring) with stall handshake.
// Optional: define MULTDIV_EARLY_OUT_EN to finish zero-operand ops in one cycle.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 exc_q, exc_d;

  logic                 start;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   fin_prod;
  logic [WIDTH-1:0]     fin_quo;
  logic                 mul_exc, div_exc;

  assign start = ctrl_mult | ctrl_div;
  assign a_mag = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
  assign b_mag = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : '0)};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_q};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign step      = div_q ? div_next : mul_next;

  assign fin_prod = sign_q ? ('0 - step) : step;
  assign mul_exc  = ~((&fin_prod[2*WIDTH-1:WIDTH-1]) | ~(|fin_prod[2*WIDTH-1:WIDTH-1]));
  assign fin_quo  = sign_q ? ('0 - step[WIDTH-1:0]) : step[WIDTH-1:0];
  // only MIN / -1 yields a positive quotient that needs the sign bit
  assign div_exc  = ~sign_q & step[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    div_d   = div_q;
    res_d   = res_q;
    exc_d   = exc_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        acc_d = step;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          res_d   = div_q ? fin_quo : fin_prod[WIDTH-1:0];
          exc_d   = div_q ? div_exc : mul_exc;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // a start in any state overrides the sequencing above (abort + restart)
    if (start) begin
      sign_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      div_d   = ~ctrl_mult;
      mag_d   = ctrl_mult ? a_mag : b_mag;
      acc_d   = {{WIDTH{1'b0}}, (ctrl_mult ? b_mag : a_mag)};
      cnt_d   = '0;
      state_d = RUN;
      if (!ctrl_mult && operand_b == '0) begin
        state_d = DONE;
        res_d   = '0;
        exc_d   = 1'b1;
      end
`ifdef MULTDIV_EARLY_OUT_EN
      else if (ctrl_mult ? (operand_a == '0 || operand_b == '0) : (operand_a == '0)) begin
        state_d = DONE;
        res_d   = '0;
        exc_d   = 1'b0;
      end
`else
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign result     = res_q;
  assign exception  = exc_q;
  assign result_rdy = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed scoreboard bench for multdiv_sequencer (WIDTH=32); honours MULTDIV_EARLY_OUT_EN.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset_n;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  multdiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    e.lat = 33;
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(e.res)));
`ifdef MULTDIV_EARLY_OUT_EN
      if (a == 0 || b == 0) e.lat = 1;
`endif
    end else if (b == 0) begin
      e.res = 32'h0;
      e.exc = 1'b1;
      e.lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = $signed(a) / $signed(b);
      e.exc = 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
      if (a == 0) e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Drives a one-cycle start; returns #1 after the sampling edge (cycle T+1).
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = m;
    ctrl_div  = d;
    operand_a = a;
    operand_b = b;
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(m, a, b));
    start_op(m, d, a, b);
  endtask

  task automatic wait_result(input string tag);
    int   k   = 1;
    bit   got = 0;
    exp_t e;
    while (k <= 40) begin
      if (result_rdy) begin
        got = 1;
        break;
      end
      check({tag, ".busy"}, 32'(busy), 32'd1);
      @(posedge clock); #1;
      k++;
    end
    check({tag, ".rdy_seen"}, 32'(got), 32'd1);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (got) begin
        check({tag, ".latency"}, 32'(k), 32'(e.lat));
        check({tag, ".busy_at_rdy"}, 32'(busy), 32'd1);
        check({tag, ".result"}, result, e.res);
        check({tag, ".exception"}, 32'(exception), 32'(e.exc));
        @(posedge clock); #1;
        check({tag, ".rdy_one_cycle"}, 32'(result_rdy), 32'd0);
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        check({tag, ".result_held"}, result, e.res);
        check({tag, ".exc_held"}, 32'(exception), 32'(e.exc));
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset.result", result, 32'h0);
    check("reset.exception", 32'(exception), 32'd0);
    check("reset.rdy", 32'(result_rdy), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    issue(1'b1, 1'b0, 32'd7, -32'sd6);
    wait_result("mul_7x-6");
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_result("mul_ovf");
    issue(1'b1, 1'b0, -32'sh8000, 32'h0001_0000);
    wait_result("mul_min_fit");

    issue(1'b0, 1'b1, -32'sd7, 32'd2);
    wait_result("div_-7/2");
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    wait_result("div_by_zero");
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_min/-1");

    // abort: the multiply never reports; only the divide does
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    for (int i = 1; i <= 9; i++) begin
      check("abort.no_rdy", 32'(result_rdy), 32'd0);
      check("abort.busy", 32'(busy), 32'd1);
      @(posedge clock); #1;
    end
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    wait_result("abort_div");
    for (int i = 0; i < 5; i++) begin
      check("abort.single_pulse", 32'(result_rdy), 32'd0);
      @(posedge clock); #1;
    end

    issue(1'b1, 1'b1, 32'd6, 32'd3);
    wait_result("both_starts");

    // asynchronous reset in the middle of a divide
    start_op(1'b0, 1'b1, -32'sd1000, 32'd7);
    for (int i = 1; i < 20; i++) begin
      @(posedge clock); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset.result", result, 32'h0);
    check("mid_reset.exception", 32'(exception), 32'd0);
    check("mid_reset.rdy", 32'(result_rdy), 32'd0);
    check("mid_reset.busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (result_rdy) check("post_reset.no_rdy", 32'(result_rdy), 32'd0);
      @(posedge clock); #1;
    end
    check("post_reset.idle", 32'(busy), 32'd0);
    issue(1'b1, 1'b0, -32'sd12, 32'd11);
    wait_result("post_reset_mul");

    issue(1'b1, 1'b0, 32'd0, 32'd123);
    wait_result("early_mul_zero");
    issue(1'b0, 1'b1, 32'd0, 32'd9);
    wait_result("early_div_zero_a");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      bit          rm;
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(0, 65535)) - 32'd32768 : $urandom;
      rm = (i % 2) == 0;
      issue(rm, ~rm, ra, rb);
      wait_result(rm ? "rand_mul" : "rand_div");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
